// File: rtl/vector_checker.sv
// Compares a stream of observed vectors against a preloaded table of expected vectors
// and reports mismatch count, first failing index and an overall pass flag per run.
module vector_checker #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_en,
   input  logic [AW-1:0]    load_addr,
   input  logic [WIDTH-1:0] load_data,
   input  logic             start,
   input  logic             obs_valid,
   input  logic [WIDTH-1:0] obs_data,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CW-1:0]    err_count,
   output logic             fail_valid,
   output logic [AW-1:0]    first_fail_idx
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic [CW-1:0]    err_q, err_d;
   logic             fail_q, fail_d;
   logic [AW-1:0]    ffi_q, ffi_d;
   logic             busy_q, done_q, pass_q;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic mismatch;
   logic last_sample;
   logic load_ok;

   assign mismatch    = (obs_data != mem_q[idx_q]);
   assign last_sample = (idx_q == AW'(DEPTH - 1));
   assign load_ok     = load_en && (state_q != StRun) && (int'(load_addr) < DEPTH);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      err_d   = err_q;
      fail_d  = fail_q;
      ffi_d   = ffi_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StRun;
               idx_d   = '0;
               err_d   = '0;
               fail_d  = 1'b0;
               ffi_d   = '0;
            end
         end
         StRun: begin
            if (obs_valid) begin
               if (mismatch) begin
                  if (err_q != CW'(DEPTH)) err_d = err_q + 1'b1;
                  // Only the first mismatch of a run captures its index.
                  if (!fail_q) begin
                     fail_d = 1'b1;
                     ffi_d  = idx_q;
                  end
               end
               if (last_sample) begin
                  idx_d   = '0;
                  state_d = StDone;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         err_q   <= '0;
         fail_q  <= 1'b0;
         ffi_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         fail_q  <= fail_d;
         ffi_q   <= ffi_d;
         busy_q  <= (state_d == StRun);
         done_q  <= (state_d == StDone);
         pass_q  <= (state_d == StDone) && (err_d == '0);
      end
   end

   // Expected-vector table deliberately survives reset.
   always_ff @(posedge clk) begin
      if (load_ok) mem_q[load_addr] <= load_data;
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign fail_valid     = fail_q;
   assign first_fail_idx = ffi_q;

endmodule
